// File: rtl/seq_divider_if.sv
// seq_divider_if: handshake and operand/result bundle for seq_divider.
//   master: drives start/a/b and observes busy/done/q/r/div_by_zero.
//   slave : the divider side.
//   start       - request, one cycle
//   a, b        - dividend / divisor (unsigned, WIDTH bits)
//   busy        - iterating
//   done        - one-cycle result-valid pulse
//   q, r        - quotient / remainder, held until next accepted start
//   div_by_zero - flags a b==0 request, held with q/r
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - seq_divider_if slave port (start/a/b in; busy/done/q/r/div_by_zero out)
// A request is accepted in IDLE or DONE. b != 0 runs WIDTH iterations (busy high),
// then done pulses for one cycle with q = a / b, r = a % b. b == 0 skips iteration
// and goes straight to DONE with q = all ones, r = a, div_by_zero = 1.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   p_q, p_d;     // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    // One restoring step.
    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] a_next;

    always_comb begin
        p_sh   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
        trial  = {1'b0, p_sh} - {2'b00, b_q};
        // Sign bit clear means the divisor fit: keep the difference.
        qbit   = ~trial[WIDTH+1];
        p_next = qbit ? trial[WIDTH:0] : p_sh;
        // Quotient bits enter at the LSB as dividend bits leave at the MSB.
        a_next = {a_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    p_d   = '0;
                    cnt_d = '0;
                    if (bus.b == '0) begin
                        q_d     = '1;
                        r_d     = bus.a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = p_next;
                a_d   = a_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    q_d     = a_next;
                    r_d     = p_next[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider at WIDTH=4.
// Reference results come from plain integer division of the requested operands.
module tb_seq_divider;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one cycle; on return the acceptance edge has passed.
    task automatic start_op(input int av, input int bv);
        bus.start = 1'b1;
        bus.a     = WIDTH'(av);
        bus.b     = WIDTH'(bv);
        tick();
        bus.start = 1'b0;
    endtask

    // Wait for done, scrambling a/b each cycle (they must not matter once captured).
    // Returns the number of edges after acceptance before done was seen.
    task automatic wait_done(input int bv, output int edges);
        edges = 0;
        while (!bus.done && edges < 20) begin
            chk("busy_while_running", int'(bus.busy), (bv != 0) ? 1 : 0);
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            tick();
            edges++;
        end
        chk("done_seen", int'(bus.done), 1);
        chk("busy_with_done", int'(bus.busy), 0);
    endtask

    task automatic check_res(input string tag, input int av, input int bv);
        int eq, er, edz;
        if (bv == 0) begin
            eq = (1 << WIDTH) - 1; er = av; edz = 1;
        end else begin
            eq = av / bv; er = av % bv; edz = 0;
        end
        chk({tag, "_q"}, int'(bus.q), eq);
        chk({tag, "_r"}, int'(bus.r), er);
        chk({tag, "_dbz"}, int'(bus.div_by_zero), edz);
    endtask

    // Full operation; leaves the bench in the done cycle.
    task automatic do_div(input string tag, input int av, input int bv);
        int edges;
        start_op(av, bv);
        wait_done(bv, edges);
        chk({tag, "_latency"}, edges, (bv == 0) ? 0 : WIDTH);
        check_res(tag, av, bv);
    endtask

    initial begin
        int edges;
        n_chk = 0;
        n_err = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_q", int'(bus.q), 0);
        chk("rst_r", int'(bus.r), 0);
        chk("rst_dbz", int'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(bus.busy), 0);

        // 13 / 3, then results hold in IDLE.
        do_div("d13_3", 13, 3);
        tick();
        chk("hold_done", int'(bus.done), 0);
        chk("hold_busy", int'(bus.busy), 0);
        check_res("hold", 13, 3);
        tick();

        // Back-to-back: second start issued in the done cycle.
        do_div("d15_1", 15, 1);
        do_div("d0_5", 0, 5);
        tick();

        // Divide by zero.
        do_div("d7_0", 7, 0);
        tick();
        chk("dbz_one_pulse", int'(bus.done), 0);

        // Start during RUN is ignored.
        start_op(9, 2);
        bus.start = 1'b1; bus.a = 4'd14; bus.b = 4'd7;
        tick();
        bus.start = 1'b0;
        wait_done(2, edges);
        chk("ign_latency", edges + 1, WIDTH);
        check_res("ign", 9, 2);
        tick();

        // Reset during RUN aborts with no done pulse.
        start_op(12, 5);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_q", int'(bus.q), 0);
        chk("abort_r", int'(bus.r), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 2 * WIDTH; i++) begin
                tick();
                seen |= int'(bus.done);
            end
            chk("abort_no_done", seen, 0);
        end

        // Exhaustive sweep, alternating idle gap and back-to-back issue.
        for (int av = 0; av < (1 << WIDTH); av++) begin
            for (int bv = 0; bv < (1 << WIDTH); bv++) begin
                do_div("sweep", av, bv);
                if (bv[0]) tick();
            end
        end
        tick();

        // Random operands with random gaps.
        for (int k = 0; k < 60; k++) begin
            int av, bv;
            av = int'($urandom_range((1 << WIDTH) - 1, 0));
            bv = int'($urandom_range((1 << WIDTH) - 1, 0));
            do_div("rand", av, bv);
            for (int g = int'($urandom_range(2, 0)); g > 0; g--) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
